// File: rtl/alu_drv_pkg.sv
// alu_drv_pkg
//   Shared definitions for the packed 8-bit ALU pin interface. The host-side
//   driver uses these to build the command word. The ALU-side wrapper uses
//   the same field positions to take it apart.
//
//   Contents:
//     state_t          driver FSM states (IDLE, DRIVE, RESP)
//     *_HI / *_LO      bit positions of sel, A and B inside the command word
//     *_W              derived field widths
//     CMD_W            command / result word width
//     pack_cmd()       builds {sel, A, B} from the three fields

package alu_drv_pkg;

    localparam int CMD_W  = 8;

    localparam int SEL_HI = 7;
    localparam int SEL_LO = 5;
    localparam int A_HI   = 4;
    localparam int A_LO   = 2;
    localparam int B_HI   = 1;
    localparam int B_LO   = 0;

    localparam int SEL_W  = SEL_HI - SEL_LO + 1;
    localparam int A_W    = A_HI - A_LO + 1;
    localparam int B_W    = B_HI - B_LO + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Place each field at its fixed position. The fields tile the word
    // exactly, so there are no padding bits to fill.
    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [SEL_W-1:0] sel,
        input logic [A_W-1:0]   a,
        input logic [B_W-1:0]   b
    );
        logic [CMD_W-1:0] cmd;
        cmd                = '0;
        cmd[SEL_HI:SEL_LO] = sel;
        cmd[A_HI:A_LO]     = a;
        cmd[B_HI:B_LO]     = b;
        return cmd;
    endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
//   Host-side driver for the packed 8-bit ALU pin interface. It accepts one
//   {sel, A, B} request and drives the packed command word onto cmd_out. It
//   holds the word for SETTLE_CYCLES cycles and then captures the ALU
//   result. The result stays on the response port until the consumer takes
//   it. Only one request is in flight at a time.
//
//   Parameters:
//     SETTLE_CYCLES  cycles cmd_out is held before res_in is sampled (1..255)
//     CNT_W          width of the completed-transaction counter
//
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     req_valid/req_ready, req_sel, req_a, req_b    request channel
//     cmd_out        registered packed command to the ALU
//     res_in         ALU result (combinational from cmd_out)
//     rsp_valid/rsp_ready, rsp_data, rsp_cmd        response channel
//     busy           high whenever the driver is not idle
//     txn_count      completed response handshakes, wraps silently

module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel,
    input  logic [A_W-1:0]   req_a,
    input  logic [B_W-1:0]   req_b,
    output logic [CMD_W-1:0] cmd_out,
    input  logic [CMD_W-1:0] res_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CMD_W-1:0] rsp_data,
    output logic [CMD_W-1:0] rsp_cmd,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    // Refuse to build with a settle time the 8-bit counter cannot express,
    // or with field positions that do not tile the command word exactly.
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("alu_cmd_driver: SETTLE_CYCLES must be in 1..255");
        end
        if (SEL_W + A_W + B_W != CMD_W) begin : g_bad_fields
            $error("alu_cmd_driver: command fields do not fill CMD_W bits");
        end
    endgenerate

    // Counts down to zero. DRIVE samples the result on the edge where the
    // counter is already zero. That gives exactly SETTLE_CYCLES DRIVE cycles.
    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

    state_t     state_reg;
    logic [7:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cmd_out   <= '0;
            rsp_data  <= '0;
            rsp_cmd   <= '0;
            rsp_valid <= 1'b0;
            txn_count <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        cmd_out   <= pack_cmd(req_sel, req_a, req_b);
                        cnt_reg   <= CNT_INIT;
                        state_reg <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_reg == 8'd0) begin
                        // Capture the command together with its result so
                        // the consumer can pair them without tracking state.
                        rsp_data  <= res_in;
                        rsp_cmd   <= cmd_out;
                        rsp_valid <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + CNT_W'(1);
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: SETTLE_CYCLES=2, CNT_W=8
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [2:0] req_sel, req_a;
    logic [1:0] req_b;
    logic [7:0] cmd_out, res_in;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data, rsp_cmd;
    logic       busy;
    logic [7:0] txn_count;

    // Wrap DUT: SETTLE_CYCLES=2, CNT_W=2
    logic       req_valid_w, req_ready_w;
    logic [7:0] cmd_out_w;
    logic       rsp_valid_w, rsp_ready_w;
    logic [7:0] rsp_data_w, rsp_cmd_w;
    logic       busy_w;
    logic [1:0] txn_count_w;

    // The ALU stand-in either follows a bench-driven value or swaps nibbles
    // of the command.
    logic       use_model;
    logic [7:0] res_drv;
    assign res_in = use_model ? {cmd_out[3:0], cmd_out[7:4]} : res_drv;

    alu_cmd_driver #(.SETTLE_CYCLES(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
        .cmd_out(cmd_out), .res_in(res_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cmd(rsp_cmd),
        .busy(busy), .txn_count(txn_count)
    );

    alu_cmd_driver #(.SETTLE_CYCLES(2), .CNT_W(2)) u_dut_w (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_w), .req_ready(req_ready_w),
        .req_sel(3'b001), .req_a(3'b010), .req_b(2'b11),
        .cmd_out(cmd_out_w), .res_in(8'h3C),
        .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready_w),
        .rsp_data(rsp_data_w), .rsp_cmd(rsp_cmd_w),
        .busy(busy_w), .txn_count(txn_count_w)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic [7:0] cmd;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Monitor: every response handshake on the main DUT is matched against
    // the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_rsp: got data 0x%0h cmd 0x%0h, required no response",
                         rsp_data, rsp_cmd);
            end else begin
                e = sb.pop_front();
                $display("txn @%0d: rsp_cmd=0x%02h rsp_data=0x%02h (exp cmd 0x%02h data 0x%02h)",
                         cyc, rsp_cmd, rsp_data, e.cmd, e.data);
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_cmd", 32'(rsp_cmd), 32'(e.cmd));
            end
        end
    end

    // Bounded wait for a signal, observed on falling edges.
    // which: 0=req_ready, 1=req_ready_w, 2=rsp_valid_w
    task automatic wait_neg(input int which, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            case (which)
                0:       ok = (req_ready === 1'b1);
                1:       ok = (req_ready_w === 1'b1);
                default: ok = (rsp_valid_w === 1'b1);
            endcase
            if (ok) break;
        end
        if (!ok) begin
            checks++;
            $display("FAIL timeout_%s: got no assertion, required within 50 cycles", name);
        end
    endtask

    int last_acc;

    // Present a request, wait for it to be accepted, and return 1 ns after
    // the accepting edge. req_valid is left high.
    task automatic issue(input logic [2:0] s, input logic [2:0] a, input logic [1:0] b,
                         input bit push, input logic [7:0] exp_data, input logic [7:0] exp_cmd);
        exp_t e;
        req_sel   = s;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        if (push) begin
            e.data = exp_data;
            e.cmd  = exp_cmd;
            sb.push_back(e);
        end
        wait_neg(0, "req_ready");
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    // Back-to-back vectors: {sel, a, b, packed cmd, nibble-swapped result}
    logic [2:0] bb_sel [4] = '{3'b001, 3'b110, 3'b011, 3'b100};
    logic [2:0] bb_a   [4] = '{3'b010, 3'b001, 3'b111, 3'b000};
    logic [1:0] bb_b   [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
    logic [7:0] bb_cmd [4] = '{8'h29, 8'hC6, 8'h7C, 8'h83};
    logic [7:0] bb_res [4] = '{8'h92, 8'h6C, 8'hC7, 8'h38};
    logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        int prev_acc;
        rst_n       = 1'b0;
        req_valid   = 1'b1;
        req_sel     = 3'b111;
        req_a       = 3'b111;
        req_b       = 2'b11;
        rsp_ready   = 1'b0;
        use_model   = 1'b0;
        res_drv     = 8'h00;
        req_valid_w = 1'b0;
        rsp_ready_w = 1'b0;

        // Reset held with a pending request: nothing may be accepted.
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_cmd_out", 32'(cmd_out), 32'h00);
            check("rst_busy", 32'(busy), 32'h0);
        end
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_txn_count", 32'(txn_count), 32'h0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        check("post_rst_cmd_out", 32'(cmd_out), 32'h00);
        check("post_rst_req_ready", 32'(req_ready), 32'h1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);

        // Packing and latency: 101_110_11 -> 0xBB, result 0x5A.
        res_drv = 8'h5A;
        issue(3'b101, 3'b110, 2'b11, 1'b1, 8'h5A, 8'hBB);
        req_valid = 1'b0;
        check("pack_cmd_out", 32'(cmd_out), 32'hBB);
        check("drive_req_ready", 32'(req_ready), 32'h0);
        check("drive_busy", 32'(busy), 32'h1);
        check("lat_e0_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        check("lat_e1_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        check("lat_e2_rsp_valid", 32'(rsp_valid), 32'h1);
        check("lat_rsp_data", 32'(rsp_data), 32'h5A);
        check("lat_rsp_cmd", 32'(rsp_cmd), 32'hBB);

        // Backpressure: the response must stay frozen while res_in moves.
        for (int i = 0; i < 10; i++) begin
            res_drv = (i % 2 == 0) ? 8'hFF : 8'h00;
            @(posedge clk); #1;
            check("bp_rsp_data", 32'(rsp_data), 32'h5A);
            check("bp_req_ready", 32'(req_ready), 32'h0);
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_txn_count", 32'(txn_count), 32'h1);
        check("bp_done_rsp_valid", 32'(rsp_valid), 32'h0);
        check("bp_done_req_ready", 32'(req_ready), 32'h1);

        // Back-to-back after a clean reset: accepts exactly 4 cycles apart.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        use_model = 1'b1;
        prev_acc  = 0;
        for (int k = 0; k < 4; k++) begin
            issue(bb_sel[k], bb_a[k], bb_b[k], 1'b1, bb_res[k], bb_cmd[k]);
            if (k > 0) check("b2b_spacing", 32'(last_acc - prev_acc), 32'd4);
            prev_acc = last_acc;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && req_ready === 1'b1) break;
        end
        check("b2b_txn_count", 32'(txn_count), 32'd4);
        check("b2b_sb_drained", 32'(sb.size()), 32'd0);

        // Mid-operation reset in the second DRIVE cycle: no response for
        // this request may ever appear. The request packs 010_011_01 -> 0x4D.
        use_model = 1'b0;
        res_drv   = 8'hC3;
        issue(3'b010, 3'b011, 2'b01, 1'b0, 8'h00, 8'h00);
        req_valid = 1'b0;
        check("mid_cmd_out", 32'(cmd_out), 32'h4D);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_cmd_out_clr", 32'(cmd_out), 32'h00);
        check("mid_req_ready", 32'(req_ready), 32'h1);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mid_no_rsp", 32'(rsp_valid), 32'h0);
        check("mid_txn_count", 32'(txn_count), 32'h0);

        // Counter wrap with CNT_W=2.
        check("wrap_start", 32'(txn_count_w), 32'h0);
        rsp_ready_w = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid_w = 1'b1;
            wait_neg(1, "req_ready_w");
            @(posedge clk); #1;
            req_valid_w = 1'b0;
            wait_neg(2, "rsp_valid_w");
            @(posedge clk); #1;
            $display("wrap txn %0d: rsp_data_w=0x%02h txn_count_w=%0d", k, rsp_data_w, txn_count_w);
            check("wrap_txn_count", 32'(txn_count_w), 32'(wrap_exp[k]));
        end
        check("wrap_rsp_data", 32'(rsp_data_w), 32'h3C);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Host-side driver for the packed 8-bit ALU pin interface. It accepts an operation request {sel, A, B} on a valid/ready port and packs it into the 8-bit command word the ALU consumes: sel in bits 7-5, A in bits 4-2, B in bits 1-0. It holds that word stable for a programmable settle time, then samples the ALU's 8-bit result and returns it on a valid/ready response port. It sits between a test/host sequencer and the ALU pins, on the far side of the ALU's io_in/io_out interface.

Parameters:
SETTLE_CYCLES, 2, cycles cmd_out is held before res_in is sampled; legal range 1..255, and 0 is a synthesis-time error.
CNT_W, 8, width of the completed-transaction counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  driver can accept a request; equals (state==IDLE)
req_sel  input  3  operation select
req_a  input  3  operand A
req_b  input  2  operand B
cmd_out  output  8  packed command to ALU: {sel, A, B}; registered
res_in  input  8  ALU result, combinational from cmd_out
rsp_valid  output  1  response holding
rsp_ready  input  1  consumer accepts response
rsp_data  output  8  captured ALU result
rsp_cmd  output  8  command word that produced rsp_data
busy  output  1  state != IDLE
txn_count  output  CNT_W  completed response handshakes; wraps modulo 2^CNT_W

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is synchronous and active-low, sampled on the rising clk edge. On reset:
  - state=IDLE
  - cmd_out=8'h00, rsp_data=8'h00, rsp_cmd=8'h00
  - rsp_valid=0, txn_count=0, internal counter=0
  - req_ready=1 and busy=0 from the first cycle after reset.
- Reset mid-operation wins over every other event. Any in-flight request is dropped and no response is produced.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: cmd_out <= {req_sel, req_a, req_b}, cnt <= SETTLE_CYCLES-1, go to DRIVE.
  - cmd_out otherwise holds its last value.
- DRIVE:
  - req_ready=0; cmd_out is stable.
  - Each edge: if cnt==0, then rsp_data <= res_in, rsp_cmd <= cmd_out, rsp_valid <= 1, go to RESP. Otherwise cnt <= cnt-1.
  - DRIVE lasts exactly SETTLE_CYCLES cycles.
- RESP:
  - rsp_valid=1; rsp_data and rsp_cmd are stable until the handshake.
  - On an edge with rsp_ready=1: rsp_valid <= 0, txn_count <= txn_count+1, go to IDLE.
  - res_in changes during RESP are ignored.
- Latency: request accepted at edge E0 gives rsp_valid=1 in the cycle after edge E0+SETTLE_CYCLES.
- Throughput: with rsp_ready tied high, the minimum spacing between accepts is SETTLE_CYCLES+2 cycles. There is no request/response overlap.
- Inputs ignored by state:
  - req_valid is ignored outside IDLE; the upstream must hold its request until req_ready.
  - rsp_ready is ignored outside RESP.
- Backpressure: rsp_ready held low keeps the driver in RESP indefinitely, with req_ready=0.
- txn_count wraps from 2^CNT_W-1 to 0 with no flag.
- Zero-width check: the three request fields concatenate to exactly 8 bits, with no padding or extension.

Decomposition:
- Package alu_drv_pkg holds:
  - the state enum (IDLE, DRIVE, RESP)
  - field constants SEL_HI=7, SEL_LO=5, A_HI=4, A_LO=2, B_HI=1, B_LO=0
  - CMD_W=8.
- The ALU-side wrapper shares the same package for field positions.
- Single module; no sub-module is warranted. The settle counter is inline.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with req_valid=1 -> cmd_out=8'h00, rsp_valid=0, req_ready=1 and txn_count=0 after release. No accept occurs while reset is low.
- Packing and latency: SETTLE_CYCLES=2; sel=3'b101, A=3'b110, B=2'b11 accepted at edge E0; bench drives res_in=8'h5A -> cmd_out=8'hBB after E0; rsp_valid rises after edge E0+2; rsp_data=8'h5A, rsp_cmd=8'hBB.
- Backpressure: rsp_ready=0 for 10 cycles while res_in toggles to 8'hFF -> rsp_data stays 8'h5A and req_ready stays 0. Raising rsp_ready completes one handshake and txn_count=1.
- Back-to-back: 4 requests with req_valid and rsp_ready tied high, SETTLE_CYCLES=2 -> accepts exactly 4 cycles apart; responses in order; txn_count=4.
- Mid-operation reset: rst_n=0 in the second DRIVE cycle -> next cycle state IDLE, rsp_valid=0, cmd_out=8'h00, and no response is ever emitted for that request.
- Wrap: CNT_W=2; 5 transactions -> txn_count sequence 1,2,3,0,1.
